eval_request: RTL

Initiator side of the board-evaluation handshake. Accepts a board from search or move-generation logic over a valid/ready interface. Drives one evaluation through an evaluator: board_valid, then wait for eval_valid, then clear_eval. Blends the returned middlegame and endgame scores by game phase, orients the result to the side to move, and returns it over a second valid/ready interface. One evaluation is in flight at a time.

---
 rtl/eval_request_if.sv | 55 +++++
 rtl/eval_request.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/eval_request_if.sv
// rtl/eval_request_if.sv - request, evaluator and result handshake bundle for eval_request
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

interface eval_request_if #(
  parameter int EVAL_WIDTH  = 24,
  parameter int PHASE_WIDTH = 8
);
  // request side: search / move generation hands over a board
  logic                    req_valid;
  logic                    req_ready;
  logic [`BOARD_WIDTH-1:0] req_board;
  logic                    req_white_to_move;
  logic [PHASE_WIDTH-1:0]  req_phase;

  // evaluator side
  logic                    ev_board_valid;
  logic [`BOARD_WIDTH-1:0] ev_board;
  logic                    ev_white_to_move;
  logic                    ev_clear_eval;
  logic                    ev_eval_valid;
  logic [EVAL_WIDTH-1:0]   ev_eval_mg;
  logic [EVAL_WIDTH-1:0]   ev_eval_eg;
  logic                    ev_insufficient_material;

  // result side
  logic                    res_valid;
  logic                    res_ready;
  logic [EVAL_WIDTH-1:0]   res_score;
  logic                    res_insufficient;
  logic                    res_timeout;

  logic                    busy;

  modport slave (
    input  req_valid, req_board, req_white_to_move, req_phase,
    input  ev_eval_valid, ev_eval_mg, ev_eval_eg, ev_insufficient_material,
    input  res_ready,
    output req_ready,
    output ev_board_valid, ev_board, ev_white_to_move, ev_clear_eval,
    output res_valid, res_score, res_insufficient, res_timeout,
    output busy
  );

  modport master (
    output req_valid, req_board, req_white_to_move, req_phase,
    output ev_eval_valid, ev_eval_mg, ev_eval_eg, ev_insufficient_material,
    output res_ready,
    input  req_ready,
    input  ev_board_valid, ev_board, ev_white_to_move, ev_clear_eval,
    input  res_valid, res_score, res_insufficient, res_timeout,
    input  busy
  );
endinterface

// File: rtl/eval_request.sv
// rtl/eval_request.sv - board evaluation initiator with phase blend; optional watchdog via EVAL_REQUEST_TIMEOUT_EN
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module eval_request #(
  parameter int EVAL_WIDTH     = 24,
  parameter int PHASE_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic           clk,
  input  logic           reset,
  eval_request_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    BLEND1 = 3'd3,
    BLEND2 = 3'd4,
    RESULT = 3'd5
  } state_t;

  // products carry the score plus the weight headroom
  localparam int PW = EVAL_WIDTH + 10;
  localparam logic signed [PW-1:0] SAT_MAX =
    $signed({{(PW-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX;

  state_t state, state_nx;

  logic [PHASE_WIDTH-1:0]       phase_q;
  logic signed [EVAL_WIDTH-1:0] mg_q, eg_q;
  logic                         ins_q;
  logic                         to_q;
  logic signed [PW-1:0]         pm, pe;
  logic signed [PW-1:0]         mg_ext, eg_ext, w_mg, w_eg;
  logic signed [PW-1:0]         sum, shifted, oriented, clipped;
  logic                         wd_expire;

`ifdef EVAL_REQUEST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // watchdog: cleared while issuing, counts every WAIT cycle without a result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (state == WAIT && !wd_expire) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  // a result arriving on the expiry cycle wins over the timeout
  assign wd_expire = (state == WAIT) && !bus.ev_eval_valid &&
                     (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (bus.ev_eval_valid || wd_expire) state_nx = BLEND1;
      BLEND1:  state_nx = BLEND2;
      BLEND2:  state_nx = RESULT;
      RESULT:  if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.ev_board_valid = (state == ISSUE);
  assign bus.ev_clear_eval  = (state == BLEND1);
  assign bus.res_valid      = (state == RESULT);
  assign bus.busy           = (state != IDLE);

  // weights: phase for middlegame, full-scale minus phase for endgame
  assign mg_ext = PW'(mg_q);
  assign eg_ext = PW'(eg_q);
  assign w_mg   = $signed(PW'(phase_q));
  assign w_eg   = $signed(PW'({1'b1, {PHASE_WIDTH{1'b0}}} - {1'b0, phase_q}));

  // floor-shift the blend, orient to side to move, zero on insufficient material, clip
  always_comb begin
    sum      = pm + pe;
    shifted  = sum >>> PHASE_WIDTH;
    oriented = bus.ev_white_to_move ? shifted : -shifted;
    if (ins_q) oriented = '0;
    clipped = oriented;
    if (oriented > SAT_MAX)      clipped = SAT_MAX;
    else if (oriented < SAT_MIN) clipped = SAT_MIN;
  end

  // captured request, evaluator result, products and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ev_board         <= '0;
      bus.ev_white_to_move <= 1'b0;
      phase_q              <= '0;
      mg_q                 <= '0;
      eg_q                 <= '0;
      ins_q                <= 1'b0;
      to_q                 <= 1'b0;
      pm                   <= '0;
      pe                   <= '0;
      bus.res_score        <= '0;
      bus.res_insufficient <= 1'b0;
      bus.res_timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.ev_board         <= bus.req_board;
            bus.ev_white_to_move <= bus.req_white_to_move;
            phase_q              <= bus.req_phase;
            to_q                 <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.ev_eval_valid) begin
            mg_q  <= $signed(bus.ev_eval_mg);
            eg_q  <= $signed(bus.ev_eval_eg);
            ins_q <= bus.ev_insufficient_material;
          end else if (wd_expire) begin
            mg_q  <= '0;
            eg_q  <= '0;
            ins_q <= 1'b0;
            to_q  <= 1'b1;
          end
        end
        BLEND1: begin
          pm <= mg_ext * w_mg;
          pe <= eg_ext * w_eg;
        end
        BLEND2: begin
          bus.res_score        <= clipped[EVAL_WIDTH-1:0];
          bus.res_insufficient <= ins_q;
          bus.res_timeout      <= to_q;
        end
        default: ;
      endcase
    end
  end

endmodule
